// File: rtl/trace_pkg.sv
// Shared types and entry layout for the CPU execution tracer.
package trace_pkg;

   typedef enum logic [1:0] {
      MODE_ALL      = 2'b00,
      MODE_REGWRITE = 2'b01,
      MODE_BRANCH   = 2'b10,
      MODE_EITHER   = 2'b11
   } trace_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } trace_state_t;

   localparam int RD_ADDR_W = 5;

   // Entry layout, LSB first: branch, regwrite, rd_data, rd_addr, instr, pc, stamp.
   localparam int OFS_BRANCH   = 0;
   localparam int OFS_REGWRITE = 1;
   localparam int OFS_RD_DATA  = 2;

   function automatic int ofs_rd_addr(input int data_w);
      return OFS_RD_DATA + data_w;
   endfunction

   function automatic int ofs_instr(input int data_w);
      return ofs_rd_addr(data_w) + RD_ADDR_W;
   endfunction

   function automatic int ofs_pc(input int data_w, input int instr_w);
      return ofs_instr(data_w) + instr_w;
   endfunction

   function automatic int ofs_stamp(input int data_w, input int instr_w);
      return ofs_pc(data_w, instr_w) + data_w;
   endfunction

   function automatic int ent_w(input int cnt_w, input int data_w, input int instr_w);
      return cnt_w + 2 * data_w + instr_w + 2 + RD_ADDR_W;
   endfunction

   // Decides whether the current cycle is worth recording under the selected mode.
   function automatic logic qualifies(input trace_mode_t mode, input logic regwrite,
                                      input logic branch);
      logic q;
      case (mode)
         MODE_ALL:      q = 1'b1;
         MODE_REGWRITE: q = regwrite;
         MODE_BRANCH:   q = branch;
         default:       q = regwrite | branch;
      endcase
      return q;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO holding trace entries; flush empties it in one cycle.
module trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 119,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             valid_o,
   output logic             full_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign valid_o = (level_o != '0);
   assign full_o  = (level_o == LW'(DEPTH));
   assign pop_ok  = pop_i & valid_o & ~flush_i;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign push_ok = push_i & ~flush_i & (~full_o | pop_ok);

   // Head is forced to zero when empty so the read port never shows stale data.
   assign rdata_o = valid_o ? mem[rd_ptr] : '0;

   // Storage array; no reset needed since reads are gated by the level.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata_i;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_o <= '0;
      end else if (flush_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_o <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   level_o <= level_o + LW'(1);
            2'b01:   level_o <= level_o - LW'(1);
            default: level_o <= level_o;
         endcase
      end
   end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Per-cycle execution tracer: time-stamps qualifying CPU cycles into a FIFO.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | waiting for start; nothing captured
//  ST_CAPTURE | stamping and recording qualifying cycles
//  ST_DONE    | window closed (limit or stop); FIFO may still be drained
module cpu_trace_buffer
   import trace_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int INSTR_W     = 32,
   parameter int DEPTH       = 16,
   parameter int CNT_W       = 16,
   parameter int CYCLE_LIMIT = 25
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 start_i,
   input  logic                                 stop_i,
   input  logic                                 clear_i,
   input  logic [1:0]                           mode_i,
   input  logic [DATA_W-1:0]                    pc_i,
   input  logic [INSTR_W-1:0]                   instr_i,
   input  logic                                 regwrite_i,
   input  logic [4:0]                           rd_addr_i,
   input  logic [DATA_W-1:0]                    rd_data_i,
   input  logic                                 branch_i,
   output logic                                 rd_valid_o,
   input  logic                                 rd_ready_i,
   output logic [CNT_W+2*DATA_W+INSTR_W+6:0]    rd_entry_o,
   output logic [$clog2(DEPTH):0]               level_o,
   output logic                                 overflow_o,
   output logic [CNT_W-1:0]                     drop_cnt_o,
   output logic                                 busy_o,
   output logic                                 done_o
);

   localparam int ENT_W       = ent_w(CNT_W, DATA_W, INSTR_W);
   localparam int OFS_RD_ADDR = ofs_rd_addr(DATA_W);
   localparam int OFS_INSTR   = ofs_instr(DATA_W);
   localparam int OFS_PC      = ofs_pc(DATA_W, INSTR_W);
   localparam int OFS_STAMP   = ofs_stamp(DATA_W, INSTR_W);
   localparam logic [CNT_W-1:0] STAMP_LAST = CNT_W'(CYCLE_LIMIT - 1);

   trace_state_t     state;
   trace_state_t     state_nxt;
   logic [CNT_W-1:0] stamp;
   logic [ENT_W-1:0] entry_d;
   logic             qual;
   logic             fifo_full;
   logic             pop;
   logic             push;
   logic             drop;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; clear overrides every other request.
   always_comb begin
      state_nxt = state;
      if (clear_i) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  state_nxt = ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (stop_i || (stamp == STAMP_LAST)) begin
                  state_nxt = ST_DONE;
               end
            end
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign busy_o = (state == ST_CAPTURE);
   assign done_o = (state == ST_DONE);

   // Cycle stamp: restarts at capture entry, advances each capture cycle, holds otherwise.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stamp <= '0;
      end else if (clear_i) begin
         stamp <= '0;
      end else if ((state == ST_IDLE) && start_i) begin
         stamp <= '0;
      end else if (state == ST_CAPTURE) begin
         stamp <= stamp + CNT_W'(1);
      end
   end

   // The limit/stop cycle itself is still recorded since state is still CAPTURE.
   assign qual = (state == ST_CAPTURE) && !clear_i
                 && qualifies(trace_mode_t'(mode_i), regwrite_i, branch_i);
   assign pop  = rd_valid_o & rd_ready_i;
   assign push = qual & (~fifo_full | pop);
   assign drop = qual & fifo_full & ~pop;

   // Pack the snooped signals into one entry word.
   always_comb begin
      entry_d                              = '0;
      entry_d[OFS_BRANCH]                  = branch_i;
      entry_d[OFS_REGWRITE]                = regwrite_i;
      entry_d[OFS_RD_DATA +: DATA_W]       = rd_data_i;
      entry_d[OFS_RD_ADDR +: RD_ADDR_W]    = rd_addr_i;
      entry_d[OFS_INSTR +: INSTR_W]        = instr_i;
      entry_d[OFS_PC +: DATA_W]            = pc_i;
      entry_d[OFS_STAMP +: CNT_W]          = stamp;
   end

   // Sticky overflow flag and saturating count of events lost to a full FIFO.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
      end else if (clear_i) begin
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
      end else if (drop) begin
         overflow_o <= 1'b1;
         if (drop_cnt_o != {CNT_W{1'b1}}) begin
            drop_cnt_o <= drop_cnt_o + CNT_W'(1);
         end
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (clear_i),
      .push_i  (push),
      .wdata_i (entry_d),
      .pop_i   (pop),
      .rdata_o (rd_entry_o),
      .valid_o (rd_valid_o),
      .full_o  (fifo_full),
      .level_o (level_o)
   );

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: expected entries are queued as cycles are driven.
module tb_cpu_trace_buffer;

   localparam int DATA_W  = 32;
   localparam int INSTR_W = 32;
   localparam int DEPTH   = 16;
   localparam int CNT_W   = 16;
   localparam int LIMIT   = 25;
   localparam int ENT_W   = CNT_W + 2 * DATA_W + INSTR_W + 7;
   localparam int LVL_W   = $clog2(DEPTH) + 1;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               start_i;
   logic               stop_i;
   logic               clear_i;
   logic [1:0]         mode_i;
   logic [DATA_W-1:0]  pc_i;
   logic [INSTR_W-1:0] instr_i;
   logic               regwrite_i;
   logic [4:0]         rd_addr_i;
   logic [DATA_W-1:0]  rd_data_i;
   logic               branch_i;
   logic               rd_valid_o;
   logic               rd_ready_i;
   logic [ENT_W-1:0]   rd_entry_o;
   logic [LVL_W-1:0]   level_o;
   logic               overflow_o;
   logic [CNT_W-1:0]   drop_cnt_o;
   logic               busy_o;
   logic               done_o;

   always #5 clk_i = ~clk_i;

   cpu_trace_buffer #(
      .DATA_W      (DATA_W),
      .INSTR_W     (INSTR_W),
      .DEPTH       (DEPTH),
      .CNT_W       (CNT_W),
      .CYCLE_LIMIT (LIMIT)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .stop_i     (stop_i),
      .clear_i    (clear_i),
      .mode_i     (mode_i),
      .pc_i       (pc_i),
      .instr_i    (instr_i),
      .regwrite_i (regwrite_i),
      .rd_addr_i  (rd_addr_i),
      .rd_data_i  (rd_data_i),
      .branch_i   (branch_i),
      .rd_valid_o (rd_valid_o),
      .rd_ready_i (rd_ready_i),
      .rd_entry_o (rd_entry_o),
      .level_o    (level_o),
      .overflow_o (overflow_o),
      .drop_cnt_o (drop_cnt_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_dut_pops = 0;

   logic [ENT_W-1:0] exp_q[$];
   int               m_state;
   logic [CNT_W-1:0] m_stamp;
   int               m_drops;
   logic             m_ovf;

   function automatic logic want(input logic [1:0] mode, input logic rw, input logic br);
      if (mode == 2'b00) return 1'b1;
      if (mode == 2'b01) return rw;
      if (mode == 2'b10) return br;
      return rw | br;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_state = 0;
      m_stamp = '0;
      m_drops = 0;
      m_ovf   = 1'b0;
   endtask

   task automatic rand_bus();
      pc_i       = $urandom;
      instr_i    = $urandom;
      rd_addr_i  = 5'($urandom);
      rd_data_i  = $urandom;
      regwrite_i = 1'($urandom);
      branch_i   = 1'($urandom);
   endtask

   // One clock: check outputs against the model, advance model, then step to next negedge.
   task automatic tick();
      logic [ENT_W-1:0] exp_e;
      logic             exp_v;
      logic             pop;
      exp_v = (exp_q.size() != 0);
      n_checks++;
      if (rd_valid_o !== exp_v) begin
         n_fail++;
         $display("FAIL rd_valid: got %b expected %b at %0t", rd_valid_o, exp_v, $time);
      end
      n_checks++;
      if (level_o !== LVL_W'(exp_q.size())) begin
         n_fail++;
         $display("FAIL level: got %0d expected %0d at %0t", level_o, exp_q.size(), $time);
      end
      n_checks++;
      if ((busy_o !== (m_state == 1)) || (done_o !== (m_state == 2))) begin
         n_fail++;
         $display("FAIL busy_done: got %b%b expected state %0d at %0t", busy_o, done_o,
                  m_state, $time);
      end
      n_checks++;
      if ((overflow_o !== m_ovf) || (drop_cnt_o !== CNT_W'(m_drops))) begin
         n_fail++;
         $display("FAIL ovf_drop: got %b/%0d expected %b/%0d at %0t", overflow_o, drop_cnt_o,
                  m_ovf, m_drops, $time);
      end
      if (rd_valid_o === 1'b1 && rd_ready_i === 1'b1) n_dut_pops++;
      pop = exp_v & rd_ready_i;
      if (pop) begin
         exp_e = exp_q.pop_front();
         n_checks++;
         if (rd_entry_o !== exp_e) begin
            n_fail++;
            $display("FAIL entry: got %h expected %h at %0t", rd_entry_o, exp_e, $time);
         end
      end
      if (clear_i) begin
         model_reset();
      end else begin
         case (m_state)
            0: if (start_i) begin
               m_state = 1;
               m_stamp = '0;
            end
            1: begin
               if (want(mode_i, regwrite_i, branch_i)) begin
                  if (exp_q.size() < DEPTH) begin
                     exp_q.push_back({m_stamp, pc_i, instr_i, rd_addr_i, rd_data_i,
                                      regwrite_i, branch_i});
                  end else begin
                     m_ovf = 1'b1;
                     if (m_drops < 65535) m_drops++;
                  end
               end
               if (stop_i || (m_stamp == CNT_W'(LIMIT - 1))) m_state = 2;
               m_stamp = m_stamp + 1'b1;
            end
            default: ;
         endcase
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic pulse_clear();
      rd_ready_i = 1'b0;
      clear_i    = 1'b1;
      tick();
      clear_i    = 1'b0;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      rand_bus();
      tick();
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk_i);
      n_checks++;
      if ({rd_valid_o, level_o, overflow_o, drop_cnt_o, busy_o, done_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_flags: got v%b l%0d o%b d%0d b%b d%b expected all 0",
                  rd_valid_o, level_o, overflow_o, drop_cnt_o, busy_o, done_o);
      end
      n_checks++;
      if (rd_entry_o !== '0) begin
         n_fail++;
         $display("FAIL reset_entry: got %h expected 0", rd_entry_o);
      end
      rst_i = 1'b0;
      model_reset();
      tick();
   endtask

   task automatic test_capture_all();
      int pops0;
      mode_i     = 2'b00;
      rd_ready_i = 1'b1;
      pulse_start();
      pops0 = n_dut_pops;
      repeat (LIMIT) begin
         rand_bus();
         tick();
      end
      repeat (2) tick();
      n_checks++;
      if (n_dut_pops - pops0 != LIMIT) begin
         n_fail++;
         $display("FAIL capture_all_count: got %0d expected %0d", n_dut_pops - pops0, LIMIT);
      end
      n_checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL capture_all_done: got done %b busy %b expected 1 0", done_o, busy_o);
      end
      pulse_clear();
   endtask

   task automatic test_overflow();
      mode_i     = 2'b00;
      rd_ready_i = 1'b0;
      pulse_start();
      repeat (LIMIT) begin
         rand_bus();
         tick();
      end
      n_checks++;
      if (level_o !== LVL_W'(16) || overflow_o !== 1'b1 || drop_cnt_o !== CNT_W'(9)) begin
         n_fail++;
         $display("FAIL overflow: got l%0d o%b d%0d expected l16 o1 d9", level_o, overflow_o,
                  drop_cnt_o);
      end
      rd_ready_i = 1'b1;
      repeat (8) tick();
      pulse_clear();
      n_checks++;
      if (level_o !== '0 || rd_valid_o !== 1'b0 || overflow_o !== 1'b0
          || drop_cnt_o !== '0 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_after_ovf: got l%0d v%b o%b d%0d dn%b expected all 0",
                  level_o, rd_valid_o, overflow_o, drop_cnt_o, done_o);
      end
   endtask

   task automatic test_full_pop();
      mode_i     = 2'b00;
      rd_ready_i = 1'b0;
      pulse_start();
      repeat (DEPTH) begin
         rand_bus();
         tick();
      end
      rd_ready_i = 1'b1;
      stop_i     = 1'b1;
      rand_bus();
      tick();
      stop_i     = 1'b0;
      rd_ready_i = 1'b0;
      n_checks++;
      if (level_o !== LVL_W'(16) || drop_cnt_o !== '0 || overflow_o !== 1'b0
          || done_o !== 1'b1) begin
         n_fail++;
         $display("FAIL full_pop: got l%0d d%0d o%b dn%b expected l16 d0 o0 dn1", level_o,
                  drop_cnt_o, overflow_o, done_o);
      end
      rd_ready_i = 1'b1;
      repeat (DEPTH + 1) tick();
      pulse_clear();
   endtask

   task automatic test_regwrite_mode();
      int pops0;
      mode_i     = 2'b01;
      rd_ready_i = 1'b1;
      pulse_start();
      pops0 = n_dut_pops;
      for (int s = 0; s < LIMIT; s++) begin
         rand_bus();
         rd_addr_i  = 5'd1;
         regwrite_i = (s == 2) || (s == 5) || (s == 9);
         rd_data_i  = (s == 2) ? 32'd7 : (s == 5) ? 32'd8 : (s == 9) ? 32'd9 : 32'd0;
         tick();
      end
      repeat (2) tick();
      n_checks++;
      if (n_dut_pops - pops0 != 3) begin
         n_fail++;
         $display("FAIL regwrite_count: got %0d expected 3", n_dut_pops - pops0);
      end
      pulse_clear();
   endtask

   task automatic test_mixed_modes();
      for (int m = 2; m < 4; m++) begin
         mode_i     = 2'(m);
         rd_ready_i = 1'b1;
         pulse_start();
         for (int s = 0; s < 12; s++) begin
            rand_bus();
            rd_ready_i = 1'($urandom);
            stop_i     = (s == 11);
            tick();
         end
         stop_i     = 1'b0;
         rd_ready_i = 1'b1;
         repeat (14) tick();
         pulse_clear();
      end
   endtask

   task automatic test_stop_clear();
      mode_i     = 2'b00;
      rd_ready_i = 1'b0;
      pulse_start();
      for (int s = 0; s < 5; s++) begin
         rand_bus();
         stop_i = (s == 4);
         tick();
      end
      stop_i = 1'b0;
      n_checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || level_o !== LVL_W'(5)) begin
         n_fail++;
         $display("FAIL stop: got dn%b b%b l%0d expected dn1 b0 l5", done_o, busy_o, level_o);
      end
      pulse_start();
      n_checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_done: got dn%b b%b expected dn1 b0", done_o, busy_o);
      end
      pulse_clear();
      n_checks++;
      if (level_o !== '0 || done_o !== 1'b0 || busy_o !== 1'b0 || overflow_o !== 1'b0
          || drop_cnt_o !== '0) begin
         n_fail++;
         $display("FAIL stop_clear: got l%0d dn%b b%b o%b d%0d expected all 0", level_o,
                  done_o, busy_o, overflow_o, drop_cnt_o);
      end
      start_i = 1'b1;
      clear_i = 1'b1;
      tick();
      start_i = 1'b0;
      clear_i = 1'b0;
      n_checks++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_over_start: got busy %b expected 0", busy_o);
      end
   endtask

   task automatic test_reset_mid();
      int pops0;
      mode_i     = 2'b00;
      rd_ready_i = 1'b0;
      pulse_start();
      repeat (6) begin
         rand_bus();
         tick();
      end
      #2 rst_i = 1'b1;
      #1;
      n_checks++;
      if ({rd_valid_o, level_o, overflow_o, drop_cnt_o, busy_o, done_o} !== '0
          || rd_entry_o !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: got v%b l%0d b%b dn%b e%h expected all 0", rd_valid_o,
                  level_o, busy_o, done_o, rd_entry_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      model_reset();
      rd_ready_i = 1'b1;
      pulse_start();
      pops0 = n_dut_pops;
      repeat (4) begin
         rand_bus();
         tick();
      end
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (n_dut_pops - pops0 != 5) begin
         n_fail++;
         $display("FAIL restart_count: got %0d expected 5", n_dut_pops - pops0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i      = 1'b1;
      start_i    = 1'b0;
      stop_i     = 1'b0;
      clear_i    = 1'b0;
      mode_i     = 2'b00;
      rd_ready_i = 1'b0;
      pc_i       = '0;
      instr_i    = '0;
      regwrite_i = 1'b0;
      rd_addr_i  = '0;
      rd_data_i  = '0;
      branch_i   = 1'b0;
      model_reset();
      test_reset();
      test_capture_all();
      test_overflow();
      test_full_pop();
      test_regwrite_mode();
      test_mixed_modes();
      test_stop_clear();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
